// File: rtl/layer_serializer.sv
// layer_serializer: captures a full layer of parallel activations and replays them as one serial burst, neuron 0 first.
// Ports: clk, reset_n (sync active-low); i_data_in/i_data_in_valid parallel neuron outputs;
//        o_data_out/o_data_out_valid serial word stream; o_busy burst in progress;
//        o_overrun sticky dropped-frame flag; o_sync_err sticky partial-valid flag.
module layer_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] i_data_in,
    input  logic [NUM_NEURONS-1:0]            i_data_in_valid,
    output logic [DATA_WIDTH-1:0]             o_data_out,
    output logic                              o_data_out_valid,
    output logic                              o_busy,
    output logic                              o_overrun,
    output logic                              o_sync_err
);
    localparam int CW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_NEURONS - 1);
    localparam logic [CW-1:0] FIRST = CW'(NUM_NEURONS > 1 ? 1 : 0);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    logic [0:0]            state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] hold [NUM_NEURONS];
    logic                  frame;
    logic                  partial;
    assign frame   = &i_data_in_valid;
    assign partial = (|i_data_in_valid) & ~frame;
    // valid stays high through the last word, so it doubles as the busy flag
    assign o_busy  = o_data_out_valid;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            count            <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) hold[k] <= '0;
            o_data_out       <= '0;
            o_data_out_valid <= 1'b0;
            o_overrun        <= 1'b0;
            o_sync_err       <= 1'b0;
        end else begin
            if (partial) o_sync_err <= 1'b1;
            if (frame && o_data_out_valid) o_overrun <= 1'b1;
            if (state == SEND) begin
                o_data_out       <= hold[count];
                o_data_out_valid <= 1'b1;
                state            <= (count == LAST) ? IDLE : SEND;
                count            <= (count == LAST) ? '0 : count + CW'(1);
            end else if (frame && !o_data_out_valid) begin
                // word 0 goes out directly from the input; the rest replay from hold
                for (int k = 0; k < NUM_NEURONS; k++) hold[k] <= i_data_in[k*DATA_WIDTH +: DATA_WIDTH];
                o_data_out       <= i_data_in[DATA_WIDTH-1:0];
                o_data_out_valid <= 1'b1;
                count            <= FIRST;
                state            <= (NUM_NEURONS > 1) ? SEND : IDLE;
            end else begin
                o_data_out_valid <= 1'b0;
            end
        end
    end
endmodule
